i2c_slave_core: RTL and testbench

//  I2C target (slave) responder: the far end of the i2c_top master. Sampled-bus design on
//  the core clock: synchronises SCL/SDA, detects START/STOP, matches a 7-bit address,

---
 rtl/i2c_slave_core_pkg.sv | 25 ++
 rtl/i2c_slave_core_if.sv | 25 ++
 rtl/i2c_slave_core_bus_sync.sv | 49 ++++
 rtl/i2c_slave_core.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_core_pkg.sv
// Shared definitions for the I2C target: FSM encoding, bus-level constants and the
// address-compare helper.
package i2c_slave_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    localparam logic       I2C_ACK            = 1'b0;
    localparam logic       I2C_NACK           = 1'b1;
    localparam logic       I2C_RW_READ        = 1'b1;
    localparam logic [7:0] I2C_UNDERFLOW_BYTE = 8'hFF;

    function automatic logic addr_hit(input logic [7:0] frame, input logic [6:0] own);
        return (frame[7:1] == own);
    endfunction

endpackage

// File: rtl/i2c_slave_core_if.sv
// Pin and byte-stream bundle of the I2C target; slave = core side, master = environment.
interface i2c_slave_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_req_o;
    logic       busy_o;
    logic       start_o;
    logic       stop_o;

    modport slave (
        input  scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        output sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, start_o, stop_o
    );

    modport master (
        output scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, busy_o, start_o, stop_o
    );
endinterface

// File: rtl/i2c_slave_core_bus_sync.sv
// SCL/SDA synchroniser plus one history flop; derives SCL edges and START/STOP events
// from the synchronised levels. All flops reset to the idle (high) bus.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_s = sda_sync_r[SYNC_STAGES-1];

    // synchroniser chains and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    // START/STOP need SCL high on both samples so an SCL edge never masquerades as one
    assign sda_lvl   = sda_s;
    assign scl_rise  = scl_s & ~scl_prev_r;
    assign scl_fall  = ~scl_s & scl_prev_r;
    assign start_det = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_det  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target responder: 7-bit address match, write bytes to a sink, read bytes from a
// source. Events act SYNC_STAGES+1 core clocks after the pin change.
module i2c_slave_core
    import i2c_slave_core_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h25,
    parameter int         SYNC_STAGES = 2
) (
    input  logic           i2c_core_clk_i,
    input  logic           rst_ni,
    i2c_slave_core_if.slave bus
);

    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_det_s;
    logic       stop_det_s;
    logic [7:0] shift_in_s;
    logic [7:0] load_byte_s;

    state_e     state_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       phase_r;
    logic       sda_oe_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       tx_req_r;
    logic       busy_r;
    logic       start_r;
    logic       stop_r;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (i2c_core_clk_i),
        .rst_n     (rst_ni),
        .scl       (bus.scl_i),
        .sda       (bus.sda_i),
        .sda_lvl   (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    assign shift_in_s  = {shift_r[6:0], sda_s};
    assign load_byte_s = bus.tx_valid_i ? bus.tx_data_i : I2C_UNDERFLOW_BYTE;

    // protocol FSM; phase_r marks that the ACK clock's rising edge has passed
    always_ff @(posedge i2c_core_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            phase_r    <= 1'b0;
            sda_oe_r   <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            busy_r     <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            if (start_det_s) begin
                start_r   <= 1'b1;
                state_r   <= ST_ADDR;
                bit_cnt_r <= 3'd0;
                phase_r   <= 1'b0;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b0;
            end else if (stop_det_s) begin
                stop_r   <= 1'b1;
                state_r  <= ST_IDLE;
                phase_r  <= 1'b0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= shift_in_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (addr_hit(shift_in_s, SLAVE_ADDR)) begin
                                    state_r <= ST_ADDR_ACK;
                                    busy_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_rise_s) begin
                            phase_r <= 1'b1;
                        end else if (scl_fall_s) begin
                            if (!phase_r) begin
                                sda_oe_r <= ~I2C_ACK;
                            end else begin
                                phase_r   <= 1'b0;
                                bit_cnt_r <= 3'd0;
                                if (state_r == ST_ADDR_ACK && shift_r[0] == I2C_RW_READ) begin
                                    shift_r  <= {load_byte_s[6:0], 1'b0};
                                    sda_oe_r <= ~load_byte_s[7];
                                    tx_req_r <= bus.tx_valid_i;
                                    state_r  <= ST_RD_DATA;
                                end else begin
                                    sda_oe_r <= 1'b0;
                                    state_r  <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= shift_in_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                rx_data_r  <= shift_in_s;
                                rx_valid_r <= 1'b1;
                                if (bus.rx_ready_i) begin
                                    state_r <= ST_WR_ACK;
                                end else begin
                                    sda_oe_r <= 1'b0;
                                    busy_r   <= 1'b0;
                                    state_r  <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        // bit_cnt_r counts master samples; it wraps to 0 after the 8th
                        if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_RD_ACK;
                            end else begin
                                sda_oe_r <= ~shift_r[7];
                                shift_r  <= {shift_r[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise_s) begin
                            if (sda_s == I2C_NACK) begin
                                busy_r  <= 1'b0;
                                state_r <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall_s) begin
                            shift_r   <= {load_byte_s[6:0], 1'b0};
                            sda_oe_r  <= ~load_byte_s[7];
                            tx_req_r  <= bus.tx_valid_i;
                            bit_cnt_r <= 3'd0;
                            state_r   <= ST_RD_DATA;
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe_o   = sda_oe_r;
    assign bus.rx_data_o  = rx_data_r;
    assign bus.rx_valid_o = rx_valid_r;
    assign bus.tx_req_o   = tx_req_r;
    assign bus.busy_o     = busy_r;
    assign bus.start_o    = start_r;
    assign bus.stop_o     = stop_r;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bit-banged I2C master driving the target, with a transaction-level expectation model
// and a per-cycle output monitor.
module tb_i2c_slave_core;

    localparam logic [6:0] DUT_ADDR = 7'h25;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_slave_core_if bus ();

    logic       scl_drv  = 1'b1;
    logic       m_low    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b1;

    assign bus.scl_i      = scl_drv;
    assign bus.sda_i      = ~(m_low | bus.sda_oe_o);
    assign bus.tx_data_i  = tx_data;
    assign bus.tx_valid_i = tx_valid;
    assign bus.rx_ready_i = rx_ready;

    i2c_slave_core #(.SLAVE_ADDR(DUT_ADDR), .SYNC_STAGES(2)) dut (
        .i2c_core_clk_i (clk),
        .rst_ni         (rst_n),
        .bus            (bus.slave)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rxq[$];
    logic [7:0] rdq[$];
    int         n_txreq = 0;
    int         n_start = 0;
    int         n_stop  = 0;
    logic       prev_oe = 1'b0;
    logic [7:0] prev_rx = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // per-cycle monitor: event capture plus output rules
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({bus.sda_oe_o, bus.rx_valid_o, bus.tx_req_o, bus.busy_o, bus.start_o,
                 bus.stop_o, bus.rx_data_o} !== 14'd0) begin
                errors++;
                $display("FAIL reset_outputs: got oe=%b busy=%b rx=%h expected all zero",
                         bus.sda_oe_o, bus.busy_o, bus.rx_data_o);
            end
        end else begin
            if (bus.rx_valid_o) rxq.push_back(bus.rx_data_o);
            if (bus.tx_req_o) n_txreq++;
            if (bus.start_o) n_start++;
            if (bus.stop_o) n_stop++;
            if (bus.sda_oe_o && !prev_oe) begin
                checks++;
                if (scl_drv) begin
                    errors++;
                    $display("FAIL drive_scl_high: got sda_oe rise with scl=1 expected scl=0");
                end
            end
            if (bus.rx_data_o !== prev_rx) begin
                checks++;
                if (!bus.rx_valid_o) begin
                    errors++;
                    $display("FAIL rx_hold: got rx_data %h->%h expected change only with rx_valid",
                             prev_rx, bus.rx_data_o);
                end
            end
        end
        prev_oe = bus.sda_oe_o;
        prev_rx = bus.rx_data_o;
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one SCL period; enters and leaves with SCL low
    task automatic clock_bit(input logic b, output logic s, input bit bchk, input logic bexp);
        ticks(4);
        m_low = ~b;
        ticks(4);
        scl_drv = 1'b1;
        ticks(4);
        s = bus.sda_i;
        if (bchk) chk("busy", {31'd0, bus.busy_o}, {31'd0, bexp});
        ticks(4);
        scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bchk, input logic bexp, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, bchk && (i != 0), bexp);
        clock_bit(1'b1, ack, 1'b0, 1'b0);
    endtask

    task automatic recv_byte(input logic bexp, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s, i != 0, bexp);
            d[i] = s;
        end
    endtask

    task automatic gen_start();
        if (!scl_drv) begin
            ticks(4);
            m_low = 1'b0;
            ticks(4);
            scl_drv = 1'b1;
        end
        ticks(4);
        m_low = 1'b1;
        ticks(8);
        scl_drv = 1'b0;
    endtask

    task automatic gen_stop();
        ticks(4);
        m_low = 1'b1;
        ticks(4);
        scl_drv = 1'b1;
        ticks(4);
        m_low = 1'b0;
        ticks(8);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d[$], input bit r[$],
                            input bit with_stop);
        logic       ack;
        bit         alive;
        logic [7:0] expq[$];
        int         s0 = n_start;
        int         p0 = n_stop;
        rxq.delete();
        gen_start();
        send_byte({a, 1'b0}, 1'b1, 1'b0, ack);
        alive = (a == DUT_ADDR);
        chk("wr_addr_ack", {31'd0, ack}, alive ? 32'd0 : 32'd1);
        chk("wr_busy_addr", {31'd0, bus.busy_o}, {31'd0, alive});
        foreach (d[k]) begin
            rx_ready = r[k];
            send_byte(d[k], 1'b1, alive, ack);
            chk("wr_data_ack", {31'd0, ack}, (alive && r[k]) ? 32'd0 : 32'd1);
            if (alive) expq.push_back(d[k]);
            alive = alive && r[k];
        end
        rx_ready = 1'b1;
        if (with_stop) gen_stop();
        ticks(4);
        chk("rx_count", rxq.size(), expq.size());
        foreach (expq[k]) if (k < rxq.size()) chk("rx_byte", {24'd0, rxq[k]}, {24'd0, expq[k]});
        chk("wr_start_cnt", n_start - s0, 32'd1);
        if (with_stop) chk("wr_stop_cnt", n_stop - p0, 32'd1);
    endtask

    task automatic do_read(input logic [6:0] a, input bit v[$], input logic [7:0] dq[$],
                           input bit with_stop);
        logic       ack;
        logic       s;
        logic [7:0] b;
        bit         match = (a == DUT_ADDR);
        int         exp_req = 0;
        int         t0 = n_txreq;
        int         s0 = n_start;
        int         n = v.size();
        rdq.delete();
        if (n > 0) begin
            tx_valid = v[0];
            tx_data  = dq[0];
        end
        gen_start();
        send_byte({a, 1'b1}, 1'b1, 1'b0, ack);
        chk("rd_addr_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        chk("rd_busy_addr", {31'd0, bus.busy_o}, {31'd0, match});
        for (int k = 0; k < n; k++) begin
            recv_byte(match, b);
            rdq.push_back(b);
            chk("rd_byte", {24'd0, b}, (match && v[k]) ? {24'd0, dq[k]} : 32'hFF);
            if (match && v[k]) exp_req++;
            if (k + 1 < n) begin
                tx_valid = v[k+1];
                tx_data  = dq[k+1];
            end
            clock_bit((k == n - 1) ? 1'b1 : 1'b0, s, 1'b0, 1'b0);
        end
        tx_valid = 1'b0;
        if (with_stop) gen_stop();
        ticks(4);
        chk("tx_req_cnt", n_txreq - t0, exp_req);
        chk("rd_start_cnt", n_start - s0, 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       s;
        logic [3:0] tail;
        logic [7:0] dq[$];
        bit         rq[$];
        bit         vq[$];
        int         p0;

        ticks(5);
        rst_n = 1'b1;
        ticks(4);
        chk("reset_sda_oe", {31'd0, bus.sda_oe_o}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("reset_rx_data", {24'd0, bus.rx_data_o}, 32'd0);

        // 1: plain write
        dq = '{8'h8A, 8'h2B, 8'hC3}; rq = '{1'b1, 1'b1, 1'b1};
        do_write(7'h25, dq, rq, 1'b1);
        chk("t1_rx0", {24'd0, rxq[0]}, 32'h8A);
        chk("t1_rx2", {24'd0, rxq[2]}, 32'hC3);

        // 2: address miss on a read
        dq = {}; vq = {};
        do_read(7'h34, vq, dq, 1'b1);

        // 3: read four bytes
        dq = '{8'h94, 8'hC5, 8'h21, 8'h84}; vq = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_read(7'h25, vq, dq, 1'b1);
        chk("t3_rd3", {24'd0, rdq[3]}, 32'h84);

        // 4: backpressure on byte 2
        dq = '{8'h11, 8'h22, 8'h33}; rq = '{1'b1, 1'b0, 1'b1};
        do_write(7'h25, dq, rq, 1'b1);
        chk("t4_rx_count", rxq.size(), 32'd2);

        // 5: underflow then repeated START into a write
        dq = '{8'h5A}; vq = '{1'b0};
        do_read(7'h25, vq, dq, 1'b0);
        chk("t5_underflow", {24'd0, rdq[0]}, 32'hFF);
        dq = '{8'hA7}; rq = '{1'b1};
        do_write(7'h25, dq, rq, 1'b1);

        // 6: reset in the 5th bit of a read of 0x00
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        gen_start();
        send_byte({7'h25, 1'b1}, 1'b1, 1'b0, ack);
        chk("t6_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s, 1'b0, 1'b0);
        tx_valid = 1'b0;
        ticks(8);
        scl_drv = 1'b1;
        ticks(2);
        chk("t6_pre_drive", {31'd0, bus.sda_oe_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", {31'd0, bus.sda_oe_o}, 32'd0);
        ticks(6);
        scl_drv = 1'b0;
        ticks(4);
        rst_n = 1'b1;
        rxq.delete();
        for (int i = 3; i >= 0; i--) begin
            clock_bit(1'b1, s, 1'b1, 1'b0);
            tail[i] = s;
        end
        chk("t6_silent", {28'd0, tail}, 32'hF);
        send_byte(8'h4A, 1'b1, 1'b0, ack);
        chk("t6_no_ack", {31'd0, ack}, 32'd1);
        chk("t6_no_rx", rxq.size(), 32'd0);
        p0 = n_stop;
        gen_stop();
        ticks(4);
        chk("t6_stop", n_stop - p0, 32'd1);
        dq = '{8'h3C}; rq = '{1'b1};
        do_write(7'h25, dq, rq, 1'b1);

        // randomized transactions
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            int         n;
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : DUT_ADDR;
            n  = $urandom_range(1, 4);
            dq = {}; rq = {}; vq = {};
            for (int k = 0; k < n; k++) begin
                dq.push_back(8'($urandom_range(0, 255)));
                rq.push_back($urandom_range(0, 3) != 0);
                vq.push_back($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 0) do_write(a, dq, rq, 1'b1);
            else do_read(a, vq, dq, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
